// File: rtl/uart_rx_if.sv
// Receiver-side bundle of the UART RX front end: divisor, serial line, CPU read
// acknowledge, and the byte/status outputs consumed by the data and status registers.
interface uart_rx_if #(
   parameter int DIV_W     = 8,
   parameter int DATA_BITS = 8
);
   logic [DIV_W-1:0]     BAUD_DIV;
   logic                 RX;
   logic                 RX_ACK;
   logic [DATA_BITS-1:0] RX_DATA;
   logic                 RX_FULL;
   logic                 RX_OVERRUN;
   logic                 RX_FRAME_ERR;
   logic                 RX_BUSY;

   modport slave (
      input  BAUD_DIV, RX, RX_ACK,
      output RX_DATA, RX_FULL, RX_OVERRUN, RX_FRAME_ERR, RX_BUSY
   );

   modport master (
      output BAUD_DIV, RX, RX_ACK,
      input  RX_DATA, RX_FULL, RX_OVERRUN, RX_FRAME_ERR, RX_BUSY
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RX, samples mid-bit using a latched baud divisor,
// and holds each byte with sticky overrun / framing status until the CPU acknowledges.
module uart_rx #(
   parameter int DIV_W     = 8,
   parameter int DATA_BITS = 8
) (
   input  logic    CLK,
   input  logic    NRESET,
   uart_rx_if.slave bus
);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 full_q, full_d;
   logic                 ovr_q, ovr_d;
   logic                 fe_q, fe_d;
   logic                 sync1_q, sync1_d;
   logic                 rxs_q, rxs_d;
   logic                 prev_q, prev_d;
   logic [DIV_W-1:0]     d_eff;
   logic                 fall;
   logic                 sample;

   // Divisors below 2 would leave no room for a half-bit start offset.
   assign d_eff  = (bus.BAUD_DIV < DIV_W'(2)) ? DIV_W'(2) : bus.BAUD_DIV;
   assign fall   = !rxs_q && prev_q;
   assign sample = (cnt_q == '0);

   always_comb begin
      sync1_d = bus.RX;
      rxs_d   = sync1_q;
      prev_d  = rxs_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      full_d  = full_q;
      ovr_d   = ovr_q;
      fe_d    = fe_q;

      // Clears first so that a set event in the same cycle overrides them.
      if (bus.RX_ACK) begin
         full_d = 1'b0;
         ovr_d  = 1'b0;
         fe_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               div_d   = d_eff;
               cnt_d   = (d_eff >> 1) - DIV_W'(1);
            end
         end
         START: begin
            if (!sample) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else if (!rxs_q) begin
               state_d = DATA;
               cnt_d   = div_q - DIV_W'(1);
               bit_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!sample) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else begin
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               cnt_d   = div_q - DIV_W'(1);
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + BW'(1);
            end
         end
         STOP: begin
            if (!sample) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else begin
               // Leave mid-stop-bit so a back-to-back start edge is not missed.
               state_d = IDLE;
               if (!rxs_q) begin
                  fe_d = 1'b1;
               end else if (!full_q || bus.RX_ACK) begin
                  data_d = shift_q;
                  full_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge NRESET) begin
      if (!NRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         full_q  <= 1'b0;
         ovr_q   <= 1'b0;
         fe_q    <= 1'b0;
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         full_q  <= full_d;
         ovr_q   <= ovr_d;
         fe_q    <= fe_d;
         sync1_q <= sync1_d;
         rxs_q   <= rxs_d;
         prev_q  <= prev_d;
      end
   end

   assign bus.RX_DATA      = data_q;
   assign bus.RX_FULL      = full_q;
   assign bus.RX_OVERRUN   = ovr_q;
   assign bus.RX_FRAME_ERR = fe_q;
   assign bus.RX_BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, expected bytes queued at send
// time and popped once the frame has been received.
module tb_uart_rx;
   logic CLK;
   logic NRESET;
   int   cyc = 0;
   int   rise_cyc = 0;
   int   busy_cnt = 0;
   logic full_prev = 1'b0;
   int   t0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_data[$];

   uart_rx_if #(.DIV_W(8), .DATA_BITS(8)) bus ();

   uart_rx #(.DIV_W(8), .DATA_BITS(8)) dut (
      .CLK    (CLK),
      .NRESET (NRESET),
      .bus    (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Observers sampled on the falling edge, away from the active edge.
   always @(negedge CLK) begin
      full_prev <= bus.RX_FULL;
      if (bus.RX_FULL && !full_prev) rise_cyc <= cyc;
      if (bus.RX_BUSY) busy_cnt <= busy_cnt + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic pulse_ack();
      bus.RX_ACK = 1'b1;
      tick();
      bus.RX_ACK = 1'b0;
      tick();
   endtask

   // Line is driven d clocks per bit; ack_at/chg_at are tick offsets from the start bit.
   task automatic send_frame(input logic [7:0] b, input int d, input bit stop_hi,
                             input int ack_at, input int chg_at);
      logic [9:0] fr;
      fr = {stop_hi, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10 * d; i++) begin
         bus.RX     = fr[i / d];
         bus.RX_ACK = (i == ack_at);
         if (i == chg_at) bus.BAUD_DIV = 8'd4;
         tick();
      end
      bus.RX     = 1'b1;
      bus.RX_ACK = 1'b0;
      repeat (4) tick();
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] e;
      e = exp_data.pop_front();
      chk(tag, 32'(bus.RX_DATA), 32'(e));
   endtask

   initial begin
      int b0;
      NRESET       = 1'b0;
      bus.RX       = 1'b1;
      bus.RX_ACK   = 1'b0;
      bus.BAUD_DIV = 8'd16;
      repeat (3) tick();
      chk("rst_data", 32'(bus.RX_DATA), 32'h0);
      chk("rst_full", 32'(bus.RX_FULL), 32'h0);
      chk("rst_ovr", 32'(bus.RX_OVERRUN), 32'h0);
      chk("rst_fe", 32'(bus.RX_FRAME_ERR), 32'h0);
      chk("rst_busy", 32'(bus.RX_BUSY), 32'h0);
      NRESET = 1'b1;
      repeat (5) tick();

      // Basic frame at D=16; full rises 3 cycles of sync/detect + stop sample + 1.
      exp_data.push_back(8'hA5);
      send_frame(8'hA5, 16, 1'b1, -1, -1);
      check_frame("a5_data");
      chk("a5_latency", 32'(rise_cyc - t0), 32'(3 + 8 + 9 * 16));
      chk("a5_full", 32'(bus.RX_FULL), 32'h1);
      chk("a5_ovr", 32'(bus.RX_OVERRUN), 32'h0);
      chk("a5_fe", 32'(bus.RX_FRAME_ERR), 32'h0);
      chk("a5_busy", 32'(bus.RX_BUSY), 32'h0);
      pulse_ack();
      chk("a5_ack_full", 32'(bus.RX_FULL), 32'h0);

      // Three-cycle glitch: rejected at the start sample.
      b0 = busy_cnt;
      bus.RX = 1'b0;
      repeat (3) tick();
      bus.RX = 1'b1;
      repeat (20) tick();
      chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
      chk("glitch_full", 32'(bus.RX_FULL), 32'h0);
      chk("glitch_fe", 32'(bus.RX_FRAME_ERR), 32'h0);
      chk("glitch_ovr", 32'(bus.RX_OVERRUN), 32'h0);

      // Overrun: second byte lost, first byte kept.
      exp_data.push_back(8'h3C);
      send_frame(8'h3C, 16, 1'b1, -1, -1);
      check_frame("ovr_first");
      exp_data.push_back(8'h3C);
      send_frame(8'hC3, 16, 1'b1, -1, -1);
      check_frame("ovr_keep");
      chk("ovr_flag", 32'(bus.RX_OVERRUN), 32'h1);
      chk("ovr_full", 32'(bus.RX_FULL), 32'h1);
      pulse_ack();
      chk("ovr_ack_full", 32'(bus.RX_FULL), 32'h0);
      chk("ovr_ack_flag", 32'(bus.RX_OVERRUN), 32'h0);

      // Framing error at D=8, then a good frame.
      bus.BAUD_DIV = 8'd8;
      send_frame(8'h55, 8, 1'b0, -1, -1);
      chk("fe_flag", 32'(bus.RX_FRAME_ERR), 32'h1);
      chk("fe_full", 32'(bus.RX_FULL), 32'h0);
      chk("fe_data", 32'(bus.RX_DATA), 32'h3C);
      exp_data.push_back(8'h0F);
      send_frame(8'h0F, 8, 1'b1, -1, -1);
      check_frame("fe_next_data");
      chk("fe_next_full", 32'(bus.RX_FULL), 32'h1);
      chk("fe_sticky", 32'(bus.RX_FRAME_ERR), 32'h1);
      pulse_ack();
      chk("fe_ack", 32'(bus.RX_FRAME_ERR), 32'h0);

      // ACK coincident with the stop sample of the next frame.
      bus.BAUD_DIV = 8'd16;
      exp_data.push_back(8'h11);
      send_frame(8'h11, 16, 1'b1, -1, -1);
      check_frame("sim_first");
      exp_data.push_back(8'h22);
      send_frame(8'h22, 16, 1'b1, 2 + 8 + 9 * 16, -1);
      check_frame("sim_data");
      chk("sim_full", 32'(bus.RX_FULL), 32'h1);
      chk("sim_ovr", 32'(bus.RX_OVERRUN), 32'h0);
      pulse_ack();

      // Divisor change mid-frame must not disturb the frame.
      exp_data.push_back(8'h96);
      send_frame(8'h96, 16, 1'b1, -1, 40);
      check_frame("divchg_data");
      chk("divchg_fe", 32'(bus.RX_FRAME_ERR), 32'h0);
      pulse_ack();

      // Divisors 0 and 1 behave as 2.
      bus.BAUD_DIV = 8'd0;
      exp_data.push_back(8'h5A);
      send_frame(8'h5A, 2, 1'b1, -1, -1);
      check_frame("div0_data");
      chk("div0_latency", 32'(rise_cyc - t0), 32'(3 + 1 + 9 * 2));
      pulse_ack();
      bus.BAUD_DIV = 8'd1;
      exp_data.push_back(8'hE1);
      send_frame(8'hE1, 2, 1'b1, -1, -1);
      check_frame("div1_data");
      chk("div1_full", 32'(bus.RX_FULL), 32'h1);

      // Asynchronous reset in the middle of a frame while a byte is held.
      bus.BAUD_DIV = 8'd16;
      bus.RX = 1'b0;
      repeat (16) tick();
      bus.RX = 1'b1;
      repeat (24) tick();
      chk("mid_busy_pre", 32'(bus.RX_BUSY), 32'h1);
      #2 NRESET = 1'b0;
      #1;
      chk("arst_data", 32'(bus.RX_DATA), 32'h0);
      chk("arst_full", 32'(bus.RX_FULL), 32'h0);
      chk("arst_busy", 32'(bus.RX_BUSY), 32'h0);
      tick();
      NRESET = 1'b1;
      repeat (10) tick();
      exp_data.push_back(8'h3A);
      send_frame(8'h3A, 16, 1'b1, -1, -1);
      check_frame("post_rst_data");
      chk("post_rst_full", 32'(bus.RX_FULL), 32'h1);
      chk("post_rst_flags", 32'({bus.RX_OVERRUN, bus.RX_FRAME_ERR}), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end of the UART. Sits directly upstream of the UART data register.
- Oversamples RX with the baud-rate divisor and deserialises 8N1 frames, LSB first.
- Holds each received byte until the CPU-side read acknowledges it.
- Reports overrun and framing errors as status flags for the status/interrupt logic.

Parameters:
DIV_W, 8, width of the baud divisor (clocks per bit).
DATA_BITS, 8, data bits per frame; RX_DATA width.

Ports:
CLK  input  1  system clock, all logic on rising edge
NRESET  input  1  asynchronous active-low reset
BAUD_DIV  input  DIV_W  clocks per bit, from baud rate divisor register
RX  input  1  asynchronous serial line, idle high
RX_ACK  input  1  one-cycle pulse: CPU has read the data register
RX_DATA  output  DATA_BITS  last accepted byte
RX_FULL  output  1  RX_DATA holds an unread byte
RX_OVERRUN  output  1  byte lost because RX_FULL was set (sticky)
RX_FRAME_ERR  output  1  stop bit sampled low (sticky)
RX_BUSY  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (NRESET low, async):
  - State IDLE, counters 0, shift register 0.
  - Synchroniser flops and previous-sample flop = 1.
  - RX_DATA=0; RX_FULL, RX_OVERRUN, RX_FRAME_ERR and RX_BUSY = 0.
  - Reset mid-frame aborts the frame with no flags.
- Synchroniser: 2 flops on RX. rxs = second flop output. Falling edge = rxs==0 and previous rxs==1.
- Divisor latch:
  - D = BAUD_DIV, captured on the start edge and used for the whole frame.
  - A D value below 2 is treated as 2.
  - BAUD_DIV changes mid-frame have no effect.
- FSM states IDLE, START, DATA, STOP. Down-counter cnt; a sample event occurs when cnt==0.
  - IDLE -> START on falling edge; cnt <= floor(D/2)-1.
  - START at sample:
    - rxs==0: go to DATA, cnt <= D-1, bit index 0.
    - rxs==1: glitch; return to IDLE with no flags.
  - DATA at sample:
    - shift rxs into MSB of shift register (LSB-first line order); cnt <= D-1.
    - After bit DATA_BITS-1, go to STOP.
  - STOP at sample: go to IDLE in the same cycle (mid-stop-bit), so a following start edge is caught.
    - rxs==1: byte delivery (below).
    - rxs==0: RX_FRAME_ERR <= 1; byte discarded.
- Timing from the cycle the falling edge is detected (cycle 0):
  - start sample at cycle floor(D/2)
  - data bit i sample at floor(D/2)+(i+1)*D
  - stop sample at floor(D/2)+9*D
  - RX_FULL/RX_DATA update on the clock after the stop sample
- Byte delivery at a good stop sample:
  - If RX_FULL==0, or RX_ACK is high in the same cycle: RX_DATA <= shift, RX_FULL <= 1.
  - Otherwise: RX_OVERRUN <= 1; RX_DATA keeps the old byte; RX_FULL stays 1.
- RX_ACK handling:
  - Clears RX_FULL, RX_OVERRUN and RX_FRAME_ERR.
  - A set event in the same cycle wins: the new byte sets RX_FULL, and a framing error sets RX_FRAME_ERR.
  - RX_ACK while RX_FULL==0 only clears the sticky flags.
- Line held low (break):
  - Frame completes with RX_FRAME_ERR set.
  - No new start until rxs returns to 1 and falls again.
- RX_BUSY = 1 in START, DATA and STOP.

Test Plan:
- D=16, send 0xA5 (line bits 1,0,1,0,0,1,0,1), stop high:
  - RX_DATA=0xA5 and RX_FULL=1 on the cycle after the stop sample, i.e. 8+9*16 = 152 cycles after edge detection.
  - No error flags.
- Glitch: RX low for 3 cycles at D=16:
  - FSM returns to IDLE at the start sample.
  - RX_FULL=0, no flags, RX_BUSY pulses high for 8 cycles.
- Overrun:
  - Receive 0x3C, no ACK, then receive 0xC3.
  - RX_DATA stays 0x3C; RX_OVERRUN=1.
  - RX_ACK then clears RX_FULL and RX_OVERRUN.
- Framing error: send 0x55 with stop bit low at D=8.
  - RX_FRAME_ERR=1; RX_FULL unchanged (0).
  - Next valid frame 0x0F is received correctly.
- Simultaneous ACK and delivery:
  - RX_FULL=1 with 0x11; RX_ACK asserted in the stop-sample cycle of frame 0x22.
  - Result: RX_DATA=0x22, RX_FULL=1, RX_OVERRUN=0.
- Divisor and reset corner cases:
  - BAUD_DIV changed from 16 to 4 mid-frame: frame still decodes at D=16.
  - BAUD_DIV=0 or 1: behaves as D=2.
  - NRESET pulsed mid-frame: all outputs 0 immediately (async); the next frame decodes normally.
